// File: rtl/iic_pkg.sv
// Shared I2C definitions: responder state encodings, bit positions and ACK levels,
// common to the responder and the master controller.
package iic_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEVADR,
        ST_ACK_DEV,
        ST_ADR_HI,
        ST_ACK_AH,
        ST_ADR_LO,
        ST_ACK_AL,
        ST_WR_BYTE,
        ST_ACK_WR,
        ST_RD_BYTE,
        ST_MACK,
        ST_WAIT_STOP
    } iic_state_e;

    localparam int         RW_BIT        = 0;
    localparam logic       BIT_ACK       = 1'b0;
    localparam logic       BIT_NACK      = 1'b1;
    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/iic_bus_sync.sv
// Brings scl/sda into the clk domain and derives edge and START/STOP strobes
// from the last two synchroniser stages.
module iic_bus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [STAGES-1:0] scl_sr;
    logic [STAGES-1:0] sda_sr;
    logic scl_new, scl_old, sda_new, sda_old;

    // Reset to the idle bus level so leaving reset never fakes an edge on a quiet bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sr <= '1;
            sda_sr <= '1;
        end else begin
            scl_sr <= {scl_sr[STAGES-2:0], scl};
            sda_sr <= {sda_sr[STAGES-2:0], sda};
        end
    end

    assign scl_new  = scl_sr[STAGES-2];
    assign scl_old  = scl_sr[STAGES-1];
    assign sda_new  = sda_sr[STAGES-2];
    assign sda_old  = sda_sr[STAGES-1];

    assign sda_lvl  = sda_new;
    assign scl_rise = scl_new & ~scl_old;
    assign scl_fall = ~scl_new & scl_old;
    assign start    = ~sda_new & sda_old & scl_new & scl_old;
    assign stop     = sda_new & ~sda_old & scl_new & scl_old;

endmodule

// File: rtl/iic_slave_resp.sv
// I2C responder with device-address match, 1/2-byte word pointer and a
// register-file style write strobe / read request interface.
module iic_slave_resp #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter bit         ADDR_16BIT  = 1'b1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic        done
);
    import iic_pkg::*;

    logic sda_s, scl_rise, scl_fall, start, stop;

    iic_state_e  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, tx_q, tx_d;
    logic [15:0] ptr_q, ptr_d;
    logic        rw_q, rw_d, rd_pend_q;
    logic        sda_oe_d, wr_en_d, rd_req_d, busy_d, done_d;
    logic [15:0] wr_addr_d, rd_addr_d;
    logic [7:0]  wr_data_d;

    iic_bus_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda_i),
        .sda_lvl  (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    // In 8-bit mode the upper pointer byte is pinned to zero and the low byte wraps alone.
    function automatic logic [15:0] ptr_next(input logic [15:0] p);
        if (ADDR_16BIT) return p + 16'd1;
        return {8'h00, p[7:0] + 8'd1};
    endfunction

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = rd_pend_q ? rd_data : tx_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        rd_req_d  = 1'b0;
        rd_addr_d = rd_addr;
        busy_d    = busy;
        done_d    = 1'b0;

        if (start) begin
            state_d   = ST_DEVADR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = busy;
        end else begin
            case (state_q)
                ST_DEVADR, ST_ADR_HI, ST_ADR_LO, ST_WR_BYTE: begin
                    // The fall right after START arrives with bit_cnt 0 and is ignored.
                    if (scl_rise && bit_cnt_q != BITS_PER_BYTE) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b1;
                        if (state_q == ST_DEVADR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_d = ST_ACK_DEV;
                                busy_d  = 1'b1;
                                rw_d    = shift_q[RW_BIT];
                                if (shift_q[RW_BIT]) begin
                                    rd_req_d  = 1'b1;
                                    rd_addr_d = ptr_q;
                                    ptr_d     = ptr_next(ptr_q);
                                end
                            end else begin
                                state_d  = ST_IDLE;
                                sda_oe_d = 1'b0;
                            end
                        end else if (state_q == ST_ADR_HI) begin
                            ptr_d   = {shift_q, ptr_q[7:0]};
                            state_d = ST_ACK_AH;
                        end else if (state_q == ST_ADR_LO) begin
                            ptr_d   = {ADDR_16BIT ? ptr_q[15:8] : 8'h00, shift_q};
                            state_d = ST_ACK_AL;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = shift_q;
                            ptr_d     = ptr_next(ptr_q);
                            state_d   = ST_ACK_WR;
                        end
                    end
                end
                ST_ACK_DEV: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d  = ST_RD_BYTE;
                            sda_oe_d = ~tx_q[7];
                        end else begin
                            state_d  = ADDR_16BIT ? ST_ADR_HI : ST_ADR_LO;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_ACK_AH: begin
                    if (scl_fall) begin
                        state_d  = ST_ADR_LO;
                        sda_oe_d = 1'b0;
                    end
                end
                ST_ACK_AL, ST_ACK_WR: begin
                    if (scl_fall) begin
                        state_d  = ST_WR_BYTE;
                        sda_oe_d = 1'b0;
                    end
                end
                ST_RD_BYTE: begin
                    // Each fall presents the next bit; after the 8th, the bus goes to the master.
                    if (scl_rise && bit_cnt_q != BITS_PER_BYTE) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == BITS_PER_BYTE) begin
                            state_d  = ST_MACK;
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d = ~tx_q[3'd7 - bit_cnt_q[2:0]];
                        end
                    end
                end
                ST_MACK: begin
                    if (scl_rise) begin
                        if (sda_s == BIT_NACK) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            state_d   = ST_RD_BYTE;
                            bit_cnt_d = '0;
                            rd_req_d  = 1'b1;
                            rd_addr_d = ptr_q;
                            ptr_d     = ptr_next(ptr_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            rd_pend_q <= 1'b0;
            sda_oe    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            rd_pend_q <= rd_req;
            sda_oe    <= sda_oe_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            rd_req    <= rd_req_d;
            rd_addr   <= rd_addr_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_iic_slave_resp.sv
// Directed I2C master sequences against iic_slave_resp with strobe scoreboards
// and a backing memory model.
module tb_iic_slave_resp;
    import iic_pkg::*;

    localparam int Q = 10;

    logic        clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_sda = 1'b1;
    logic        sda_oe, wr_en, rd_req, busy, done, sda_bus;
    logic [15:0] wr_addr, rd_addr;
    logic [7:0]  wr_data, rd_data;
    int          checks = 0, errors = 0, done_cnt = 0;
    logic [23:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [23:0] wr_head;
    logic [15:0] rd_head;
    logic [7:0]  mem   [0:65535];
    bit          mem_v [0:65535];
    logic        ack, b;
    logic [7:0]  d;

    assign sda_bus = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    iic_slave_resp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl     (scl),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory backing the read port: written bytes, else a fixed address pattern.
    always @(posedge clk) begin
        if (!rst_n) rd_data <= 8'h00;
        else begin
            if (wr_en) begin
                mem[wr_addr]   <= wr_data;
                mem_v[wr_addr] <= 1'b1;
            end
            if (rd_req) rd_data <= mem_v[rd_addr] ? mem[rd_addr] : (rd_addr[7:0] ^ 8'hC3);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (wr_en) begin
                chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    wr_head = exp_wr.pop_front();
                    chk("wr_addr_data", {wr_addr, wr_data}, wr_head);
                end
            end
            if (rd_req) begin
                chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) begin
                    rd_head = exp_rd.pop_front();
                    chk("rd_addr", rd_addr, rd_head);
                end
            end
        end
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wq();
        scl = 1'b1;   wq();
        m_sda = 1'b0; wq();
        scl = 1'b0;   wq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wq();
        scl = 1'b1;   wq();
        m_sda = 1'b1; wq(); wq();
    endtask

    task automatic wbit(input logic v);
        m_sda = v;  wq();
        scl = 1'b1; wq(); wq();
        scl = 1'b0; wq();
    endtask

    task automatic rbit(output logic v);
        m_sda = 1'b1; wq();
        scl = 1'b1;   wq();
        v = sda_bus;  wq();
        scl = 1'b0;   wq();
    endtask

    task automatic send(input logic [7:0] v, output logic a);
        for (int i = 7; i >= 0; i--) wbit(v[i]);
        rbit(a);
    endtask

    task automatic send_ack(input string tag, input logic [7:0] v);
        logic a;
        send(v, a);
        chk(tag, a, BIT_ACK);
    endtask

    task automatic recv(output logic [7:0] v, input logic mack);
        logic t;
        for (int i = 7; i >= 0; i--) begin
            rbit(t);
            v[i] = t;
        end
        wbit(mack);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        wq();

        // Single-byte write at 0x005A
        exp_wr.push_back({16'h005A, 8'h55});
        i2c_start();
        send_ack("t1_ack_dev", 8'hA0);
        chk("t1_busy", busy, 1);
        send_ack("t1_ack_ah", 8'h00);
        send_ack("t1_ack_al", 8'h5A);
        send_ack("t1_ack_wr", 8'h55);
        i2c_stop();
        chk("t1_done", done_cnt, 1);
        chk("t1_busy_end", busy, 0);

        // Random read of 0x005A via repeated START
        i2c_start();
        send_ack("t2_ack_dev", 8'hA0);
        send_ack("t2_ack_ah", 8'h00);
        send_ack("t2_ack_al", 8'h5A);
        i2c_start();
        exp_rd.push_back(16'h005A);
        send_ack("t2_ack_rd", 8'hA1);
        recv(d, BIT_NACK);
        chk("t2_data", d, 8'h55);
        chk("t2_released", sda_oe, 0);
        i2c_stop();
        chk("t2_done", done_cnt, 2);

        // Foreign device address
        i2c_start();
        send(8'hA4, ack);
        chk("t3_nack", ack, BIT_NACK);
        chk("t3_busy", busy, 0);
        i2c_stop();
        chk("t3_no_done", done_cnt, 2);

        // Pointer wrap on burst write
        exp_wr.push_back({16'hFFFF, 8'h11});
        exp_wr.push_back({16'h0000, 8'h22});
        i2c_start();
        send_ack("t4_ack_dev", 8'hA0);
        send_ack("t4_ack_ah", 8'hFF);
        send_ack("t4_ack_al", 8'hFF);
        send_ack("t4_ack_d0", 8'h11);
        send_ack("t4_ack_d1", 8'h22);
        i2c_stop();
        chk("t4_done", done_cnt, 3);

        // Sequential read of 3 bytes from 0x0010
        i2c_start();
        send_ack("t5_ack_dev", 8'hA0);
        send_ack("t5_ack_ah", 8'h00);
        send_ack("t5_ack_al", 8'h10);
        i2c_start();
        exp_rd.push_back(16'h0010);
        exp_rd.push_back(16'h0011);
        exp_rd.push_back(16'h0012);
        send_ack("t5_ack_rd", 8'hA1);
        recv(d, BIT_ACK);
        chk("t5_d0", d, 8'hD3);
        recv(d, BIT_ACK);
        chk("t5_d1", d, 8'hD2);
        recv(d, BIT_NACK);
        chk("t5_d2", d, 8'hD1);
        i2c_stop();
        chk("t5_done", done_cnt, 4);

        // STOP after 4 data bits: partial byte dropped
        i2c_start();
        send_ack("t6_ack_dev", 8'hA0);
        send_ack("t6_ack_ah", 8'h00);
        send_ack("t6_ack_al", 8'h20);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
        i2c_stop();
        chk("t6_sda_oe", sda_oe, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done_cnt, 5);

        // Reset while driving a 0 bit of read data (0x0040 -> 0x83)
        i2c_start();
        send_ack("t7_ack_dev", 8'hA0);
        send_ack("t7_ack_ah", 8'h00);
        send_ack("t7_ack_al", 8'h40);
        i2c_start();
        exp_rd.push_back(16'h0040);
        send_ack("t7_ack_rd", 8'hA1);
        rbit(b);
        chk("t7_bit7", b, 1);
        chk("t7_driving", sda_oe, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t7_async_sda_oe", sda_oe, 0);
        chk("t7_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        i2c_stop();
        chk("t7_no_done", done_cnt, 5);

        // Current-address read after reset starts at pointer 0x0000
        exp_rd.push_back(16'h0000);
        i2c_start();
        send_ack("t8_ack_rd", 8'hA1);
        recv(d, BIT_NACK);
        chk("t8_data", d, 8'h22);
        i2c_stop();
        chk("t8_done", done_cnt, 6);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
